// File: rtl/pc_ctrl_pkg.sv
// Operation encodings for the program-counter / return-address-stack sequencer.
// Shared by the decoder, the prog_ctr_stack block and its bench.
package pc_ctrl_pkg;

    localparam logic [2:0] PC_HOLD  = 3'b000;
    localparam logic [2:0] PC_LOAD  = 3'b001;
    localparam logic [2:0] PC_INC   = 3'b010;
    localparam logic [2:0] PC_REL   = 3'b011;
    localparam logic [2:0] PC_CALL  = 3'b100;
    localparam logic [2:0] PC_RET   = 3'b101;
    localparam logic [2:0] PC_SKIP  = 3'b110;
    localparam logic [2:0] PC_FLUSH = 3'b111;

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: one push or pop per cycle, push ignored when full,
// pop ignored when empty, flush empties it. Storage is zeroed on clr.
module ras_lifo #(
    parameter  int D_WIDTH   = 8,
    parameter  int STK_DEPTH = 4,
    localparam int LVL_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata,
    output logic [LVL_W-1:0]   level,
    output logic               empty,
    output logic               full
);

    logic [D_WIDTH-1:0] mem_reg [STK_DEPTH];
    logic [LVL_W-1:0]   level_reg;
    logic [STK_DEPTH-1:0] wr_en;
    logic               push_ok;
    logic               pop_ok;

    assign empty   = (level_reg == LVL_W'(0));
    assign full    = (level_reg == LVL_W'(STK_DEPTH));
    assign push_ok = push && !flush && !full;
    assign pop_ok  = pop && !flush && !push && !empty;

    // The slot written by a push is the one just above the current top.
    generate
        for (genvar gi = 0; gi < STK_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (level_reg == LVL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level_reg <= '0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STK_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
            if (flush) begin
                level_reg <= '0;
            end else if (push_ok) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (pop_ok) begin
                level_reg <= level_reg - LVL_W'(1);
            end
        end
    end

    // Top-of-stack select; reads zero when empty.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < STK_DEPTH; i++) begin
            if (level_reg == LVL_W'(i + 1)) begin
                rdata = mem_reg[i];
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/prog_ctr_stack.sv
// Program counter with signed relative branch, skip and call/return via ras_lifo.
// Optional sticky overflow/underflow flag stk_err when PC_STACK_ERR_EN is defined.
module prog_ctr_stack
    import pc_ctrl_pkg::*;
#(
    parameter  int D_WIDTH   = 8,
    parameter  int STK_DEPTH = 4,
    localparam int LVL_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [D_WIDTH-1:0] pc_in,
    input  logic [2:0]         pc_ctrl,
    output logic [D_WIDTH-1:0] pc_out,
    output logic [LVL_W-1:0]   stk_level,
    output logic               stk_empty,
    output logic               stk_full
`ifdef PC_STACK_ERR_EN
    ,
    output logic               stk_err
`endif
);

    logic [D_WIDTH-1:0] pc_reg;
    logic [D_WIDTH-1:0] pc_next;
    logic [D_WIDTH-1:0] pc_plus1;
    logic [D_WIDTH-1:0] ras_rdata;
    logic               ras_empty;
    logic               ras_full;
    logic               is_call;
    logic               is_ret;
    logic               is_flush;

    assign is_call  = (pc_ctrl == PC_CALL);
    assign is_ret   = (pc_ctrl == PC_RET);
    assign is_flush = (pc_ctrl == PC_FLUSH);
    assign pc_plus1 = pc_reg + D_WIDTH'(1);

    ras_lifo #(
        .D_WIDTH   (D_WIDTH),
        .STK_DEPTH (STK_DEPTH)
    ) u_ras (
        .clk   (clk),
        .clr   (clr),
        .push  (is_call),
        .pop   (is_ret),
        .flush (is_flush),
        .wdata (pc_plus1),
        .rdata (ras_rdata),
        .level (stk_level),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // All sums wrap modulo 2^D_WIDTH; pc_in is a signed offset for REL.
    always_comb begin
        pc_next = pc_reg;
        case (pc_ctrl)
            PC_LOAD: pc_next = pc_in;
            PC_INC:  pc_next = pc_plus1;
            PC_REL:  pc_next = pc_reg + pc_in;
            PC_CALL: pc_next = pc_in;
            PC_RET:  pc_next = ras_empty ? pc_plus1 : ras_rdata;
            PC_SKIP: pc_next = pc_reg + D_WIDTH'(2);
            default: pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

`ifdef PC_STACK_ERR_EN
    logic err_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_reg <= 1'b0;
        end else if (is_flush) begin
            err_reg <= 1'b0;
        end else if ((is_call && ras_full) || (is_ret && ras_empty)) begin
            err_reg <= 1'b1;
        end
    end

    assign stk_err = err_reg;
`endif

    assign pc_out    = pc_reg;
    assign stk_empty = ras_empty;
    assign stk_full  = ras_full;

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Directed bench for prog_ctr_stack (D_WIDTH=8, STK_DEPTH=4); stk_err checks
// are compiled in only when PC_STACK_ERR_EN is defined.
module tb_prog_ctr_stack;
    import pc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] pc_in;
    logic [2:0] pc_ctrl;
    logic [7:0] pc_out;
    logic [2:0] stk_level;
    logic       stk_empty;
    logic       stk_full;
`ifdef PC_STACK_ERR_EN
    logic       stk_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    prog_ctr_stack #(.D_WIDTH(8), .STK_DEPTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .pc_in     (pc_in),
        .pc_ctrl   (pc_ctrl),
        .pc_out    (pc_out),
        .stk_level (stk_level),
        .stk_empty (stk_empty),
        .stk_full  (stk_full)
`ifdef PC_STACK_ERR_EN
        ,
        .stk_err   (stk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic [7:0] din,
                        input logic [7:0] exp_pc, input int exp_lvl, input string tag);
        pc_ctrl = op;
        pc_in   = din;
        @(posedge clk);
        #1;
        $display("op=%0d in=0x%02h -> pc=0x%02h lvl=%0d (%s)", op, din, pc_out, stk_level, tag);
        check({tag, ".pc"}, 32'(pc_out), 32'(exp_pc));
        check({tag, ".lvl"}, 32'(stk_level), 32'(exp_lvl));
    endtask

    task automatic check_err(input string tag, input logic exp);
`ifdef PC_STACK_ERR_EN
        check({tag, ".err"}, 32'(stk_err), 32'(exp));
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    initial begin
        clr     = 1'b0;
        pc_ctrl = PC_HOLD;
        pc_in   = 8'h00;
        #12;
        check("rst.pc", 32'(pc_out), 32'h0);
        check("rst.lvl", 32'(stk_level), 32'h0);
        check("rst.empty", 32'(stk_empty), 32'h1);
        check("rst.full", 32'(stk_full), 32'h0);
        check_err("rst", 1'b0);
        clr = 1'b1;

        // Wrap and relative branch
        step(PC_LOAD, 8'hFE, 8'hFE, 0, "load_fe");
        step(PC_INC,  8'h00, 8'hFF, 0, "inc_ff");
        step(PC_INC,  8'h00, 8'h00, 0, "inc_wrap");
        step(PC_LOAD, 8'h10, 8'h10, 0, "load_10");
        step(PC_REL,  8'hFC, 8'h0C, 0, "rel_m4");
        step(PC_REL,  8'h05, 8'h11, 0, "rel_p5");
        step(PC_LOAD, 8'hFF, 8'hFF, 0, "load_ff");
        step(PC_SKIP, 8'h00, 8'h01, 0, "skip_wrap");
        step(PC_HOLD, 8'h55, 8'h01, 0, "hold");

        // Nested call/return
        step(PC_LOAD, 8'h10, 8'h10, 0, "n_load");
        step(PC_CALL, 8'h40, 8'h40, 1, "n_call1");
        step(PC_CALL, 8'h80, 8'h80, 2, "n_call2");
        step(PC_RET,  8'h00, 8'h41, 1, "n_ret1");
        step(PC_RET,  8'h00, 8'h11, 0, "n_ret2");
        check("n.empty", 32'(stk_empty), 32'h1);

        // Overflow
        step(PC_LOAD, 8'h00, 8'h00, 0, "o_load");
        step(PC_CALL, 8'h10, 8'h10, 1, "o_call1");
        step(PC_CALL, 8'h20, 8'h20, 2, "o_call2");
        step(PC_CALL, 8'h30, 8'h30, 3, "o_call3");
        check("o.full3", 32'(stk_full), 32'h0);
        check_err("o_pre", 1'b0);
        step(PC_CALL, 8'h40, 8'h40, 4, "o_call4");
        check("o.full4", 32'(stk_full), 32'h1);
        step(PC_CALL, 8'h99, 8'h99, 4, "o_call5");
        check_err("o_call5", 1'b1);
        step(PC_RET,  8'h00, 8'h31, 3, "o_ret1");
        step(PC_RET,  8'h00, 8'h21, 2, "o_ret2");
        step(PC_RET,  8'h00, 8'h11, 1, "o_ret3");
        step(PC_RET,  8'h00, 8'h01, 0, "o_ret4");
        check_err("o_sticky", 1'b1);
        step(PC_FLUSH, 8'h00, 8'h01, 0, "o_flush");
        check_err("o_flush", 1'b0);

        // Underflow and FLUSH
        step(PC_LOAD, 8'h20, 8'h20, 0, "u_load");
        step(PC_RET,  8'h00, 8'h21, 0, "u_ret");
        check("u.empty", 32'(stk_empty), 32'h1);
        check_err("u_ret", 1'b1);
        step(PC_FLUSH, 8'h00, 8'h21, 0, "u_flush");
        check_err("u_flush", 1'b0);

        // FLUSH with entries, then fall-through RET; CALL then immediate RET
        step(PC_CALL, 8'h50, 8'h50, 1, "f_call1");
        step(PC_CALL, 8'h60, 8'h60, 2, "f_call2");
        step(PC_FLUSH, 8'h00, 8'h60, 0, "f_flush");
        step(PC_RET,  8'h00, 8'h61, 0, "f_ret");
        step(PC_CALL, 8'h70, 8'h70, 1, "cr_call");
        step(PC_RET,  8'h00, 8'h62, 0, "cr_ret");

        // Reset mid-run with level 2 and error set
        step(PC_LOAD, 8'h00, 8'h00, 0, "r_load");
        step(PC_RET,  8'h00, 8'h01, 0, "r_uflow");
        step(PC_CALL, 8'h10, 8'h10, 1, "r_call1");
        step(PC_CALL, 8'h35, 8'h35, 2, "r_call2");
        step(PC_INC,  8'h00, 8'h36, 2, "r_inc1");
        step(PC_INC,  8'h00, 8'h37, 2, "r_inc2");
        check_err("r_pre", 1'b1);
        pc_ctrl = PC_HOLD;
        #2;
        clr = 1'b0;
        #1;
        check("mid_rst.pc", 32'(pc_out), 32'h0);
        check("mid_rst.lvl", 32'(stk_level), 32'h0);
        check("mid_rst.empty", 32'(stk_empty), 32'h1);
        check("mid_rst.full", 32'(stk_full), 32'h0);
        check_err("mid_rst", 1'b0);
        #2;
        clr = 1'b1;
        step(PC_RET,  8'h00, 8'h01, 0, "post_rst_ret");
        step(PC_SKIP, 8'h00, 8'h03, 0, "post_rst_skip");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
